// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the programmable clock-enable divider.
// Optional build macro affecting users of this package: CLKDIV_SYNC_EN.
package clk_div_pkg;

    localparam int CNT_W_DEFAULT = 8;
    localparam int DIV_DEFAULT_N = 6;

    typedef logic [CNT_W_DEFAULT-1:0] div_t;

    // Threshold at which the divided level goes high: N>>1.
    function automatic logic [31:0] half_div(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Divisor shadow register: captures runtime loads and hands them over to the
// active divisor only at a period boundary.
// Build macro: CLKDIV_SYNC_EN adds sync_in, which also counts as a boundary.
module clk_div_shadow
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DIV_DEFAULT = DIV_DEFAULT_N
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    input  logic             term,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    output logic [CNT_W-1:0] div_cur,
    output logic             div_pend,
    output logic             load_err
);

    logic [CNT_W-1:0] div_shadow;
    logic             boundary;
    logic             apply;
    logic             load_ok;
    logic             load_zero;

`ifdef CLKDIV_SYNC_EN
    assign boundary  = term | sync_in;
`else
    assign boundary  = term;
`endif
    assign apply     = boundary & div_pend;
    assign load_ok   = div_load & (div_val != '0);
    assign load_zero = div_load & (div_val == '0);

    // Active divisor only changes at a boundary, and only if a load is waiting.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cur <= CNT_W'(DIV_DEFAULT);
        end else if (apply) begin
            div_cur <= div_shadow;
        end
    end

    // Last valid load wins; a load on the boundary cycle lands after the hand-over.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_shadow <= CNT_W'(DIV_DEFAULT);
        end else if (load_ok) begin
            div_shadow <= div_val;
        end
    end

    // Pending flag: set by a valid load, cleared by the hand-over; set wins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_pend <= 1'b0;
        end else if (load_ok) begin
            div_pend <= 1'b1;
        end else if (apply) begin
            div_pend <= 1'b0;
        end
    end

    // A zero divisor is rejected and flagged for one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load_zero;
        end
    end

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock-enable generator. Emits a 1-cycle
// clk_flag every N enabled cycles and a near-50% clk_out level. Not a clock.
// Build macro: CLKDIV_SYNC_EN adds sync_in for phase-aligning several dividers.
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DIV_DEFAULT = DIV_DEFAULT_N
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             clk_flag,
    output logic             clk_out,
    output logic             div_pend,
    output logic             load_err,
    output logic [CNT_W-1:0] cnt_out
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] half;
    logic             term;

    // div_cur is never zero, so div_cur-1 cannot wrap.
    assign term    = en & (cnt == (div_cur - CNT_W'(1)));
    assign half    = CNT_W'(half_div(32'(div_cur)));
    assign cnt_out = cnt;

    clk_div_shadow #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_shadow (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .div_load  (div_load),
        .div_val   (div_val),
        .term      (term),
`ifdef CLKDIV_SYNC_EN
        .sync_in   (sync_in),
`endif
        .div_cur   (div_cur),
        .div_pend  (div_pend),
        .load_err  (load_err)
    );

    // Period counter with flag and level; en=0 freezes count and level.
`ifdef CLKDIV_SYNC_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt      <= '0;
            clk_flag <= 1'b0;
            clk_out  <= 1'b0;
        end else if (sync_in) begin
            cnt      <= '0;
            clk_flag <= 1'b1;
            clk_out  <= 1'b0;
        end else if (en) begin
            cnt      <= term ? '0 : cnt + CNT_W'(1);
            clk_flag <= term;
            clk_out  <= (cnt >= half);
        end else begin
            clk_flag <= 1'b0;
        end
    end
`else
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt      <= '0;
            clk_flag <= 1'b0;
            clk_out  <= 1'b0;
        end else if (en) begin
            cnt      <= term ? '0 : cnt + CNT_W'(1);
            clk_flag <= term;
            clk_out  <= (cnt >= half);
        end else begin
            clk_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: directed scenarios plus random
// traffic, compared cycle by cycle against a period-level reference model.
module tb_clk_divider_prog;

    localparam int CNT_W = 8;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             clk_flag;
    logic             clk_out;
    logic             div_pend;
    logic             load_err;
    logic [CNT_W-1:0] cnt_out;
`ifdef CLKDIV_SYNC_EN
    logic             sync_in;
`endif

    int total = 0;
    int bad   = 0;

    // reference model: position within the current period and divisor bookkeeping
    int m_pos, m_n, m_shadow;
    bit m_pend, m_flag, m_out, m_err;
    bit sync_drv = 1'b0;

    always #5 sys_clk = ~sys_clk;

    clk_divider_prog dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .div_val   (div_val),
        .div_load  (div_load),
`ifdef CLKDIV_SYNC_EN
        .sync_in   (sync_in),
`endif
        .clk_flag  (clk_flag),
        .clk_out   (clk_out),
        .div_pend  (div_pend),
        .load_err  (load_err),
        .cnt_out   (cnt_out)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_n = 6; m_shadow = 6;
        m_pend = 0; m_flag = 0; m_out = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit e, input bit ld, input int v);
        bit fin;
        bit apply;
        fin   = e && (m_pos == m_n - 1);
        m_err = ld && (v == 0);
        if (sync_drv) begin
            apply  = m_pend;
            m_pos  = 0;
            m_flag = 1;
            m_out  = 0;
        end else begin
            apply = fin && m_pend;
            if (e) begin
                m_flag = fin;
                m_out  = (m_pos >= m_n / 2);
                m_pos  = fin ? 0 : m_pos + 1;
            end else begin
                m_flag = 0;
            end
        end
        if (apply) begin
            m_n    = m_shadow;
            m_pend = 0;
        end
        if (ld && v != 0) begin
            m_shadow = v;
            m_pend   = 1;
        end
    endtask

    task automatic compare_all();
        check_val("cnt",  32'(cnt_out),  32'(m_pos));
        check_val("flag", 32'(clk_flag), 32'(m_flag));
        check_val("out",  32'(clk_out),  32'(m_out));
        check_val("pend", 32'(div_pend), 32'(m_pend));
        check_val("err",  32'(load_err), 32'(m_err));
    endtask

    task automatic step(input bit e, input bit ld, input int v);
        @(negedge sys_clk);
        en       = e;
        div_load = ld;
        div_val  = CNT_W'(v);
`ifdef CLKDIV_SYNC_EN
        sync_in  = sync_drv;
`endif
        @(posedge sys_clk);
        model_edge(e, ld, v);
        #1;
        compare_all();
    endtask

    task automatic wait_flag(output int gap);
        bit done;
        done = 0;
        gap  = 0;
        for (int i = 0; i < 600; i++) begin
            step(1, 0, 0);
            gap++;
            if (clk_flag === 1'b1) begin
                done = 1;
                break;
            end
        end
        if (!done) check_val("wait_flag_timeout", 0, 1);
    endtask

    task automatic run_to(input int target);
        bit done;
        done = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_pos == target) begin
                done = 1;
                break;
            end
            step(1, 0, 0);
        end
        if (!done) check_val("run_to_timeout", 0, 1);
    endtask

    initial begin
        int gap;
        int highs;
        int flags;

        sys_rst_n = 1'b0;
        en        = 1'b0;
        div_load  = 1'b0;
        div_val   = '0;
`ifdef CLKDIV_SYNC_EN
        sync_in   = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge sys_clk);
        compare_all();
        sys_rst_n = 1'b1;

        // default divide-by-6
        wait_flag(gap);
        check_val("gap_default", gap, 6);
        highs = 0;
        flags = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            if (clk_out) highs++;
            if (clk_flag) flags++;
        end
        check_val("highs_n6", highs, 3);
        check_val("flags_n6", flags, 1);

        // runtime change to 4 mid-period
        run_to(2);
        step(1, 1, 4);
        check_val("pend_after_load", 32'(div_pend), 1);
        wait_flag(gap);
        check_val("gap_finish_old", gap, 3);
        check_val("pend_cleared", 32'(div_pend), 0);
        wait_flag(gap);
        check_val("gap_new_4", gap, 4);

        // load on the terminal cycle while another value is pending
        run_to(1);
        step(1, 1, 4);
        run_to(3);
        step(1, 1, 3);
        check_val("flag_on_term_load", 32'(clk_flag), 1);
        wait_flag(gap);
        check_val("gap_pending_4", gap, 4);
        wait_flag(gap);
        check_val("gap_then_3", gap, 3);

        // zero load rejected, then overwrite 9 with 5
        step(1, 1, 0);
        check_val("load_err_pulse", 32'(load_err), 1);
        step(1, 0, 0);
        check_val("load_err_clear", 32'(load_err), 0);
        wait_flag(gap);
        wait_flag(gap);
        check_val("gap_after_zero", gap, 3);
        step(1, 1, 9);
        step(1, 1, 5);
        wait_flag(gap);
        wait_flag(gap);
        check_val("gap_overwrite_a", gap, 5);
        wait_flag(gap);
        check_val("gap_overwrite_b", gap, 5);

        // enable drop at cnt=3 with N=5
        run_to(3);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0);
            check_val("cnt_frozen", 32'(cnt_out), 3);
        end
        wait_flag(gap);
        check_val("gap_resume", gap, 2);
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            if (clk_out) highs++;
        end
        check_val("highs_n5", highs, 3);

`ifdef CLKDIV_SYNC_EN
        run_to(3);
        sync_drv = 1'b1;
        step(0, 0, 0);
        sync_drv = 1'b0;
        check_val("sync_cnt", 32'(cnt_out), 0);
        check_val("sync_flag", 32'(clk_flag), 1);
`endif

        // N=1: flag every cycle, level constant high
        step(1, 1, 1);
        wait_flag(gap);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            check_val("n1_flag", 32'(clk_flag), 1);
            check_val("n1_out", 32'(clk_out), 1);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit e, ld;
            int v;
            e  = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 9) == 0);
            v  = $urandom_range(0, 12);
            step(e, ld, v);
        end

        // async reset mid-period with a pending load
        step(1, 1, 9);
        check_val("pend_before_rst", 32'(div_pend), 1);
        #2;
        sys_rst_n = 1'b0;
        en        = 1'b0;
        div_load  = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_flag(gap);
        check_val("gap_after_rst", gap, 6);
        wait_flag(gap);
        check_val("gap_after_rst_b", gap, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
